// File: rtl/avalon_ram_slave.sv
// Avalon-MM word RAM slave with fixed wait states and a side-band preload port.
// Define RAM_RANDOM_WAIT_EN to draw each transfer's wait count from an 8-bit LFSR.
module avalon_ram_slave #(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [3:0]        xfer_wait;
  logic              start, capture;
  logic              req;
  logic [ADDR_W-1:0] word_idx, load_idx;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  assign req      = read | write;
  assign word_idx = address[ADDR_W+1:2];
  assign load_idx = load_addr[ADDR_W+1:2];

  // Reset gates the handshake so the master never stalls on a dead slave.
  assign waitrequest = reset & req & (state != S_RESP);

`ifdef RAM_RANDOM_WAIT_EN
  localparam logic [4:0] WAIT_MOD = 5'(WAIT_CYCLES + 1);
  logic [7:0] lfsr;
  logic [4:0] wait_mod_res;

  assign wait_mod_res = {1'b0, lfsr[3:0]} % WAIT_MOD;
  assign xfer_wait    = wait_mod_res[3:0];

  // Fibonacci LFSR, taps 8,6,5,4; steps once per accepted transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     lfsr <= LFSR_SEED;
    else if (start) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0],
                              load_addr[31:ADDR_W+2], load_addr[1:0]};
`else
  assign xfer_wait = 4'(WAIT_CYCLES);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0],
                              load_addr[31:ADDR_W+2], load_addr[1:0], LFSR_SEED};
`endif

  // A wait count of k gives k WAIT cycles, so waitrequest is high for k+1
  // cycles including the IDLE cycle in which the request is first seen.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && !load_en) begin
          start = 1'b1;
          if (xfer_wait == 4'd0) begin
            state_nxt = S_RESP;
            capture   = read & ~write;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = xfer_wait - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (!load_en) begin
          if (cnt == 4'd0) begin
            state_nxt = S_RESP;
            capture   = read & ~write;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture never coincides with a load (load_en freezes the FSM), so a read
  // always sees a fully loaded word.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      readdata <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) readdata <= mem[word_idx];
    end
  end

  // NOTE: the array has no reset; its contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == S_RESP && write) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[word_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
    // Later assignment wins, so a preload beats a bus write to the same word.
    if (load_en) mem[load_idx] <= load_data;
  end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Self-checking bench for avalon_ram_slave: directed scenarios plus randomized
// back-to-back traffic checked against an array model and the latency formula.
module tb_avalon_ram_slave;

  localparam int ADDR_W = 8;
`ifdef RAM_RANDOM_WAIT_EN
  localparam int WC      = 3;
  localparam int LAT_MIN = 1;
`else
  localparam int WC      = 1;
  localparam int LAT_MIN = WC + 1;
`endif
  localparam int LAT_MAX = WC + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, writedata, readdata, load_addr, load_data;
  logic        read, write, waitrequest, load_en;
  logic [3:0]  byteenable;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_rd;

  avalon_ram_slave #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .waitrequest(waitrequest), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    ref_mem[widx(a)] = d;
  endtask

  // One complete handshake; returns readdata seen in the RESP cycle and the
  // number of waitrequest-high cycles.
  task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rdv, output int hi);
    bit done = 0;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    hi = 0; rdv = 'x;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (waitrequest) hi++;
      else begin rdv = readdata; done = 1; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout addr=%h: waitrequest still high after 40 cycles, required low", a);
    end
    tick();
    read = 1'b0; write = 1'b0;
    if (wr) model_write(a, wd, be);
  endtask

  task automatic test_reset;
    reset = 1'b0; read = 1'b1; write = 1'b0; address = 32'h4;
    writedata = '0; byteenable = 4'hF; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (waitrequest !== 1'b0) begin errors++;
      $display("FAIL reset_waitrequest got %b required 0", waitrequest); end
    checks++;
    if (readdata !== 32'h0) begin errors++;
      $display("FAIL reset_readdata got %h required 00000000", readdata); end
    tick();
    read = 1'b0;
    reset = 1'b1;
    tick();
    exp_rd = 32'h0;
  endtask

  task automatic test_preload_read;
    logic [31:0] r; int hi;
    preload(32'h04, 32'h24020010);
    bus_xfer(1, 0, 32'h04, '0, 4'h0, r, hi);
    exp_rd = ref_mem[widx(32'h04)];
    checks++;
    if (hi < LAT_MIN || hi > LAT_MAX) begin errors++;
      $display("FAIL preload_read_latency got %0d required %0d..%0d", hi, LAT_MIN, LAT_MAX); end
    checks++;
    if (r !== 32'h24020010) begin errors++;
      $display("FAIL preload_read_data got %h required 24020010", r); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] r; int hi;
    preload(32'h20, 32'h11223344);
    bus_xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, r, hi);
    bus_xfer(1, 0, 32'h20, '0, 4'h0, r, hi);
    exp_rd = 32'h11BB33DD;
    checks++;
    if (r !== 32'h11BB33DD) begin errors++;
      $display("FAIL byte_enable got %h required 11BB33DD", r); end
    checks++;
    if (ref_mem[widx(32'h20)] !== 32'h11BB33DD) begin errors++;
      $display("FAIL byte_enable_model got %h required 11BB33DD", ref_mem[widx(32'h20)]); end
  endtask

  task automatic test_alias;
    logic [31:0] r; int hi;
    preload(32'h04, 32'h00000008);
    bus_xfer(1, 0, 32'h404, '0, 4'h0, r, hi);
    exp_rd = 32'h8;
    checks++;
    if (r !== 32'h00000008) begin errors++;
      $display("FAIL alias_0x404 got %h required 00000008", r); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] r; int hi;
    preload(32'h30, 32'h0);
    write = 1'b1; address = 32'h30; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (waitrequest !== 1'b0) begin errors++;
      $display("FAIL abort_waitrequest got %b required 0", waitrequest); end
    checks++;
    if (readdata !== 32'h0) begin errors++;
      $display("FAIL abort_readdata got %h required 00000000", readdata); end
    write = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus_xfer(1, 0, 32'h30, '0, 4'h0, r, hi);
    exp_rd = 32'h0;
    checks++;
    if (r !== 32'h0) begin errors++;
      $display("FAIL abort_no_commit got %h required 00000000", r); end
  endtask

  task automatic test_load_freeze;
    int hi; bit done;
    // Load asserted together with the request: the transfer must not start.
    preload(32'h08, 32'h12345678);
    read = 1'b1; address = 32'h08;
    load_en = 1'b1; load_addr = 32'h08; load_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (waitrequest !== 1'b1) begin errors++;
        $display("FAIL load_hold_cycle%0d waitrequest got %b required 1", c, waitrequest); end
      tick();
    end
    load_en = 1'b0;
    ref_mem[widx(32'h08)] = 32'hCAFEF00D;
    hi = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (waitrequest) hi++; else done = 1;
    end
    checks++;
    if (!done || hi < LAT_MIN || hi > LAT_MAX) begin errors++;
      $display("FAIL load_hold_latency got %0d required %0d..%0d", hi, LAT_MIN, LAT_MAX); end
    checks++;
    if (readdata !== 32'hCAFEF00D) begin errors++;
      $display("FAIL load_hold_data got %h required CAFEF00D", readdata); end
    tick();
    read = 1'b0;
    exp_rd = 32'hCAFEF00D;
`ifndef RAM_RANDOM_WAIT_EN
    // Load arriving once the transfer is already in WAIT: counter frozen.
    preload(32'h08, 32'h0);
    read = 1'b1; address = 32'h08;
    tick();
    load_en = 1'b1; load_addr = 32'h08; load_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (waitrequest !== 1'b1) begin errors++;
        $display("FAIL load_freeze_cycle%0d waitrequest got %b required 1", c, waitrequest); end
      tick();
    end
    load_en = 1'b0;
    ref_mem[widx(32'h08)] = 32'hCAFEF00D;
    hi = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (waitrequest) hi++; else done = 1;
    end
    checks++;
    if (!done || hi != WC) begin errors++;
      $display("FAIL load_freeze_latency got %0d required %0d", hi, WC); end
    checks++;
    if (readdata !== 32'hCAFEF00D) begin errors++;
      $display("FAIL load_freeze_data got %h required CAFEF00D", readdata); end
    tick();
    read = 1'b0;
`endif
  endtask

  task automatic test_load_wins;
    logic [31:0] r; int hi; bit done = 0;
    preload(32'h40, 32'h0);
    write = 1'b1; address = 32'h40; writedata = 32'h55555555; byteenable = 4'hF;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!waitrequest) done = 1;
    end
    load_en = 1'b1; load_addr = 32'h40; load_data = 32'h0BADBEEF;
    tick();
    write = 1'b0; load_en = 1'b0;
    ref_mem[widx(32'h40)] = 32'h0BADBEEF;
    bus_xfer(1, 0, 32'h40, '0, 4'h0, r, hi);
    exp_rd = 32'h0BADBEEF;
    checks++;
    if (!done || r !== 32'h0BADBEEF) begin errors++;
      $display("FAIL load_wins got %h required 0BADBEEF", r); end
  endtask

  task automatic test_rw_both;
    logic [31:0] r; int hi;
    preload(32'h44, 32'h01010101);
    bus_xfer(1, 1, 32'h44, 32'h77777777, 4'b1100, r, hi);
    checks++;
    if (r !== exp_rd) begin errors++;
      $display("FAIL rw_both_readdata got %h required %h", r, exp_rd); end
    bus_xfer(1, 0, 32'h44, '0, 4'h0, r, hi);
    exp_rd = 32'h77770101;
    checks++;
    if (r !== 32'h77770101) begin errors++;
      $display("FAIL rw_both_commit got %h required 77770101", r); end
  endtask

  task automatic test_drop;
    logic [31:0] r; int hi;
    preload(32'h50, 32'h01020304);
    write = 1'b1; address = 32'h50; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    tick();
    write = 1'b0;
    #1;
    checks++;
    if (waitrequest !== 1'b0) begin errors++;
      $display("FAIL drop_waitrequest got %b required 0", waitrequest); end
    tick();
    bus_xfer(1, 0, 32'h50, '0, 4'h0, r, hi);
    exp_rd = 32'h01020304;
    checks++;
    if (r !== 32'h01020304) begin errors++;
      $display("FAIL drop_no_commit got %h required 01020304", r); end
  endtask

  task automatic test_random_back_to_back;
    logic [31:0] r, a, d, exp; int hi; logic [3:0] be;
    bit seen [0:15];
    for (int i = 0; i < 16; i++) seen[i] = 0;
    for (int i = 0; i < 16; i++) preload(32'(i * 4), $urandom);
    for (int n = 0; n < 100; n++) begin
      a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 3) << 10));
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: preload(a, d);
        1: bus_xfer(0, 1, a, d, be, r, hi);
        default: begin
          exp = ref_mem[widx(a)];
          bus_xfer(1, 0, a, '0, 4'h0, r, hi);
          exp_rd = exp;
          checks++;
          if (r !== exp) begin errors++;
            $display("FAIL rand_read%0d addr=%h got %h required %h", n, a, r, exp); end
          checks++;
          if (hi < LAT_MIN || hi > LAT_MAX) begin errors++;
            $display("FAIL rand_latency%0d got %0d required %0d..%0d", n, hi, LAT_MIN, LAT_MAX); end
          else seen[hi-1] = 1;
        end
      endcase
    end
`ifdef RAM_RANDOM_WAIT_EN
    for (int k = 0; k <= WC; k++) begin
      checks++;
      if (seen[k] !== 1'b1) begin errors++;
        $display("FAIL rand_wait_coverage count %0d observed %0d required 1", k, seen[k]); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_byte_enable();
    test_alias();
    test_reset_abort();
    test_load_freeze();
    test_load_wins();
    test_rw_both();
    test_drop();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
